// File: rtl/adc_responder_if.sv
// ============================================================================
// Module   : adc_responder_if
// Brief    : Sample handshake, serial ADC link and status for adc_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface adc_responder_if #(
    parameter int SAMPLE_WIDTH = 12
);
    logic                    adc_clk;
    logic                    adc_cs;
    logic                    adc_sd;
    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic                    sample_valid;
    logic                    sample_ready;
    logic                    busy;
    logic                    frame_done;
    logic                    underrun;
    logic                    aborted;

    // master: sample source plus the ADC capture side driving the link
    modport master (
        output adc_clk, adc_cs, sample_in, sample_valid,
        input  adc_sd, sample_ready, busy, frame_done, underrun, aborted
    );

    modport slave (
        input  adc_clk, adc_cs, sample_in, sample_valid,
        output adc_sd, sample_ready, busy, frame_done, underrun, aborted
    );
endinterface

`default_nettype wire

// File: rtl/adc_responder.sv
// ============================================================================
// Module   : adc_responder
// Brief    : Fabric-side 12-bit serial ADC model; serialises one held sample
//            per chip-select frame onto adc_sd, MSB first after lead zeros.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adc_responder #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int LEAD_ZEROS   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    adc_responder_if.slave     bus
);

    localparam int c_FRAME_BITS = LEAD_ZEROS + SAMPLE_WIDTH;
    localparam int c_CNT_W      = (c_FRAME_BITS > 1) ? $clog2(c_FRAME_BITS) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_TRAIL = 2'd2;

    logic                    w_sclk_s;
    logic                    w_cs_s;
    logic                    r_sclk_d;
    logic                    r_cs_d;
    logic                    r_cs_fall;
    logic                    r_cs_rise;
    logic                    r_sclk_fall;

    logic [1:0]              r_state;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic                    r_sd;
    logic                    r_frame_done;
    logic                    r_underrun;
    logic                    r_aborted;

    logic [SAMPLE_WIDTH-1:0] r_hold;
    logic                    r_hold_full;
    logic [SAMPLE_WIDTH-1:0] r_last;

    logic                    w_load;
    logic                    w_start;
    logic                    w_empty_start;
    logic [SAMPLE_WIDTH-1:0] w_sample;
    logic [c_FRAME_BITS-1:0] w_frame;
    logic [c_FRAME_BITS-1:0] w_shift_next;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] r_sclk_pipe;
            logic [SYNC_STAGES-1:0] r_cs_pipe;

            // Idle levels are high so release from reset never looks like an edge
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_sclk_pipe <= '1;
                    r_cs_pipe   <= '1;
                end else begin
                    r_sclk_pipe <= (r_sclk_pipe << 1) | SYNC_STAGES'(bus.adc_clk);
                    r_cs_pipe   <= (r_cs_pipe << 1)   | SYNC_STAGES'(bus.adc_cs);
                end
            end

            assign w_sclk_s = r_sclk_pipe[SYNC_STAGES-1];
            assign w_cs_s   = r_cs_pipe[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_sclk_s = bus.adc_clk;
            assign w_cs_s   = bus.adc_cs;
        end
    endgenerate

    // Edge flags are registered, giving SYNC_STAGES+2 cycles pin-to-adc_sd
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sclk_d    <= 1'b1;
            r_cs_d      <= 1'b1;
            r_cs_fall   <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_sclk_fall <= 1'b0;
        end else begin
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
            r_cs_fall   <= r_cs_d & ~w_cs_s;
            r_cs_rise   <= ~r_cs_d & w_cs_s;
            r_sclk_fall <= r_sclk_d & ~w_sclk_s;
        end
    end

    assign w_load        = bus.sample_valid & ~r_hold_full;
    assign w_start       = (r_state == c_ST_IDLE) & r_cs_fall;
    assign w_empty_start = w_start & ~r_hold_full & ~w_load;

    // An empty register with a same-cycle load hands sample_in straight through
    always_comb begin
        w_sample = r_last;
        if (r_hold_full) begin
            w_sample = r_hold;
        end else if (w_load) begin
            w_sample = bus.sample_in;
        end
    end

    assign w_frame      = c_FRAME_BITS'(w_sample);
    assign w_shift_next = r_shift << 1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_last      <= '0;
        end else begin
            if (w_start) begin
                r_hold_full <= 1'b0;
                r_last      <= w_sample;
            end else if (w_load) begin
                r_hold_full <= 1'b1;
                r_hold      <= bus.sample_in;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_sd         <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            r_aborted    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_sd <= 1'b0;
                    if (r_cs_fall) begin
                        r_shift    <= w_frame;
                        r_sd       <= w_frame[c_FRAME_BITS-1];
                        r_bit_cnt  <= '0;
                        r_underrun <= w_empty_start;
                        r_state    <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (r_cs_rise) begin
                        r_aborted <= 1'b1;
                        r_sd      <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end else if (r_sclk_fall) begin
                        if (r_bit_cnt == c_CNT_W'(c_FRAME_BITS - 1)) begin
                            r_sd         <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= c_ST_TRAIL;
                        end else begin
                            r_shift   <= w_shift_next;
                            r_sd      <= w_shift_next[c_FRAME_BITS-1];
                            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                        end
                    end
                end
                c_ST_TRAIL: begin
                    r_sd <= 1'b0;
                    if (r_cs_rise) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_sd    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.adc_sd       = r_sd;
    assign bus.sample_ready = ~r_hold_full;
    assign bus.busy         = (r_state != c_ST_IDLE);
    assign bus.frame_done   = r_frame_done;
    assign bus.underrun     = r_underrun;
    assign bus.aborted      = r_aborted;

endmodule

`default_nettype wire
